// File: rtl/risc_spm_pkg.sv
// Shared types and defaults for the RISC SPM memory subsystem.
package risc_spm_pkg;

  localparam int AW_DEFAULT = 8;
  localparam int DW_DEFAULT = 8;
  localparam int CNT_W      = 16;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Up-counter that stops at max_i; clr_i takes priority over inc_i.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] max_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (inc_i && (q_q != max_i)) begin
      q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the CPU (priority) and the program loader,
// with a starvation guard for the loader and a lock mode for boot images.
module mem_port_arbiter
  import risc_spm_pkg::*;
#(
  parameter int AW         = AW_DEFAULT,
  parameter int DW         = DW_DEFAULT,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cpu_req_i,
  input  logic             cpu_we_i,
  input  logic [AW-1:0]    cpu_addr_i,
  input  logic [DW-1:0]    cpu_wdata_i,
  output logic [DW-1:0]    cpu_rdata_o,
  output logic             cpu_gnt_o,
  output logic             cpu_stall_o,
  input  logic             ldr_req_i,
  input  logic             ldr_we_i,
  input  logic [AW-1:0]    ldr_addr_i,
  input  logic [DW-1:0]    ldr_wdata_i,
  input  logic             ldr_lock_i,
  output logic [DW-1:0]    ldr_rdata_o,
  output logic             ldr_gnt_o,
  output logic [AW-1:0]    mem_addr_o,
  output logic [DW-1:0]    mem_wdata_o,
  output logic             mem_write_o,
  input  logic [DW-1:0]    mem_rdata_i,
  output logic             locked_o,
  output logic [CNT_W-1:0] conflict_cnt_o
);

  localparam int            SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  arb_state_t    state_q, state_d;
  logic          cpu_gnt, ldr_gnt;
  logic [SW-1:0] starve_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB;
    end else begin
      state_q <= state_d;
    end
  end

  // Grants are forced low during reset so a pending write never reaches memory.
  always_comb begin
    state_d = state_q;
    cpu_gnt = 1'b0;
    ldr_gnt = 1'b0;
    if (!rst_i) begin
      case (state_q)
        ARB: begin
          if (ldr_req_i && (ldr_lock_i || !cpu_req_i || (starve_cnt == STARVE_LIM))) begin
            ldr_gnt = 1'b1;
            if (ldr_lock_i) state_d = LOCK;
          end else if (cpu_req_i) begin
            cpu_gnt = 1'b1;
          end
        end
        LOCK: begin
          ldr_gnt = ldr_req_i;
          if (!ldr_lock_i) state_d = ARB;
        end
        default: state_d = ARB;
      endcase
    end
  end

  always_comb begin
    mem_addr_o  = cpu_addr_i;
    mem_wdata_o = cpu_wdata_i;
    mem_write_o = 1'b0;
    if (ldr_gnt) begin
      mem_addr_o  = ldr_addr_i;
      mem_wdata_o = ldr_wdata_i;
      mem_write_o = ldr_we_i;
    end else if (cpu_gnt) begin
      mem_write_o = cpu_we_i;
    end
  end

  sat_counter #(.W(SW)) u_starve_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (ldr_gnt | ~ldr_req_i),
    .inc_i (ldr_req_i & ~ldr_gnt),
    .max_i (STARVE_LIM),
    .q_o   (starve_cnt)
  );

  sat_counter #(.W(CNT_W)) u_conflict_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (1'b0),
    .inc_i (cpu_req_i & ldr_req_i),
    .max_i ({CNT_W{1'b1}}),
    .q_o   (conflict_cnt_o)
  );

  assign cpu_gnt_o   = cpu_gnt;
  assign ldr_gnt_o   = ldr_gnt;
  assign cpu_stall_o = cpu_req_i & ~cpu_gnt;
  assign cpu_rdata_o = mem_rdata_i;
  assign ldr_rdata_o = mem_rdata_i;
  assign locked_o    = (state_q == LOCK);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: two instances (STARVE_MAX 4 and 1)
// driven by the same requester stimulus, with a 256x8 memory model.
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_we, ldr_req, ldr_we, ldr_lock;
  logic [7:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;

  logic [7:0]  cpu_rdata, ldr_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_gnt, cpu_stall, ldr_gnt, mem_write, locked;
  logic [15:0] conflict_cnt;

  logic [7:0]  d1_cpu_rdata, d1_ldr_rdata, d1_mem_addr, d1_mem_wdata;
  logic        d1_cpu_gnt, d1_cpu_stall, d1_ldr_gnt, d1_mem_write, d1_locked;
  logic [15:0] d1_conflict_cnt;

  int checks = 0;
  int errors = 0;
  logic exp_l;

  logic [7:0] mem [256] = '{default: 8'h00};
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(8), .DW(8), .STARVE_MAX(4)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata), .cpu_gnt_o(cpu_gnt), .cpu_stall_o(cpu_stall),
    .ldr_req_i(ldr_req), .ldr_we_i(ldr_we), .ldr_addr_i(ldr_addr), .ldr_wdata_i(ldr_wdata),
    .ldr_lock_i(ldr_lock), .ldr_rdata_o(ldr_rdata), .ldr_gnt_o(ldr_gnt),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_write_o(mem_write),
    .mem_rdata_i(mem_rdata), .locked_o(locked), .conflict_cnt_o(conflict_cnt)
  );

  mem_port_arbiter #(.AW(8), .DW(8), .STARVE_MAX(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(d1_cpu_rdata), .cpu_gnt_o(d1_cpu_gnt), .cpu_stall_o(d1_cpu_stall),
    .ldr_req_i(ldr_req), .ldr_we_i(ldr_we), .ldr_addr_i(ldr_addr), .ldr_wdata_i(ldr_wdata),
    .ldr_lock_i(ldr_lock), .ldr_rdata_o(d1_ldr_rdata), .ldr_gnt_o(d1_ldr_gnt),
    .mem_addr_o(d1_mem_addr), .mem_wdata_o(d1_mem_wdata), .mem_write_o(d1_mem_write),
    .mem_rdata_i(mem_rdata), .locked_o(d1_locked), .conflict_cnt_o(d1_conflict_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with both requesters writing
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h01; cpu_wdata = 8'hFF;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 8'h02; ldr_wdata = 8'hEE; ldr_lock = 1'b0;
    @(negedge clk);
    chk("rst_cpu_gnt", cpu_gnt, 0);
    chk("rst_ldr_gnt", ldr_gnt, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_cpu_stall", cpu_stall, 1);
    chk("rst_locked", locked, 0);
    next_cyc();
    next_cyc();
    chk("rst_conflict", conflict_cnt, 0);

    // Idle: default mux selects CPU address, no write
    rst = 1'b0;
    cpu_req = 1'b0; ldr_req = 1'b0; cpu_addr = 8'h33;
    @(negedge clk);
    chk("idle_cpu_gnt", cpu_gnt, 0);
    chk("idle_ldr_gnt", ldr_gnt, 0);
    chk("idle_mem_write", mem_write, 0);
    chk("idle_mem_addr", mem_addr, 8'h33);
    next_cyc();
    chk("idle_conflict", conflict_cnt, 0);

    // CPU alone: write 0xA5 to 0x10, then read it back
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 8'hA5;
    @(negedge clk);
    chk("cpuw_gnt", cpu_gnt, 1);
    chk("cpuw_stall", cpu_stall, 0);
    chk("cpuw_mem_write", mem_write, 1);
    chk("cpuw_mem_addr", mem_addr, 8'h10);
    chk("cpuw_mem_wdata", mem_wdata, 8'hA5);
    next_cyc();
    cpu_we = 1'b0;
    @(negedge clk);
    chk("cpur_gnt", cpu_gnt, 1);
    chk("cpur_mem_write", mem_write, 0);
    chk("cpur_rdata", cpu_rdata, 8'hA5);
    next_cyc();

    // Loader alone: write 0x5A to 0x20, then read it back
    cpu_req = 1'b0;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 8'h20; ldr_wdata = 8'h5A;
    @(negedge clk);
    chk("ldrw_gnt", ldr_gnt, 1);
    chk("ldrw_cpu_gnt", cpu_gnt, 0);
    chk("ldrw_mem_addr", mem_addr, 8'h20);
    chk("ldrw_mem_wdata", mem_wdata, 8'h5A);
    chk("ldrw_mem_write", mem_write, 1);
    next_cyc();
    ldr_we = 1'b0;
    @(negedge clk);
    chk("ldrr_gnt", ldr_gnt, 1);
    chk("ldrr_rdata", ldr_rdata, 8'h5A);
    next_cyc();

    // Contention: CPUx4, LDR pattern (STARVE_MAX=4); alternation for STARVE_MAX=1
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 8'h20; ldr_lock = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      exp_l = (i == 4) || (i == 9);
      chk($sformatf("cont%0d_cpu_gnt", i), cpu_gnt, !exp_l);
      chk($sformatf("cont%0d_ldr_gnt", i), ldr_gnt, exp_l);
      chk($sformatf("cont%0d_cpu_stall", i), cpu_stall, exp_l);
      chk($sformatf("cont%0d_mem_addr", i), mem_addr, exp_l ? 8'h20 : 8'h10);
      chk($sformatf("cont%0d_rdata", i), cpu_rdata, exp_l ? 8'h5A : 8'hA5);
      chk($sformatf("cont%0d_d1_ldr_gnt", i), d1_ldr_gnt, (i % 2) == 1);
      chk($sformatf("cont%0d_d1_cpu_gnt", i), d1_cpu_gnt, (i % 2) == 0);
      next_cyc();
    end
    chk("cont_conflict", conflict_cnt, 10);
    chk("cont_d1_conflict", d1_conflict_cnt, 10);

    // Lock: loader wins with lock under contention at cycle t
    ldr_lock = 1'b1; ldr_we = 1'b1; ldr_addr = 8'h40; ldr_wdata = 8'h11;
    @(negedge clk);
    chk("lock_t_ldr_gnt", ldr_gnt, 1);
    chk("lock_t_cpu_gnt", cpu_gnt, 0);
    chk("lock_t_locked", locked, 0);
    next_cyc();
    for (int j = 1; j < 20; j++) begin
      ldr_req = (j == 10);
      ldr_we = 1'b0;
      @(negedge clk);
      chk($sformatf("lock%0d_locked", j), locked, 1);
      chk($sformatf("lock%0d_cpu_gnt", j), cpu_gnt, 0);
      chk($sformatf("lock%0d_cpu_stall", j), cpu_stall, 1);
      chk($sformatf("lock%0d_ldr_gnt", j), ldr_gnt, j == 10);
      if (j == 10) chk("lock10_ldr_rdata", ldr_rdata, 8'h11);
      next_cyc();
    end
    ldr_lock = 1'b0; ldr_req = 1'b0; cpu_addr = 8'h40;
    @(negedge clk);
    chk("lock20_cpu_gnt", cpu_gnt, 0);
    chk("lock20_locked", locked, 1);
    next_cyc();
    @(negedge clk);
    chk("lock21_cpu_gnt", cpu_gnt, 1);
    chk("lock21_locked", locked, 0);
    chk("lock21_rdata", cpu_rdata, 8'h11);
    next_cyc();
    chk("lock_conflict", conflict_cnt, 12);

    // Reset in the middle of a lock
    cpu_req = 1'b0;
    ldr_req = 1'b1; ldr_lock = 1'b1; ldr_we = 1'b1; ldr_addr = 8'h50; ldr_wdata = 8'h77;
    @(negedge clk);
    chk("rlock_t_ldr_gnt", ldr_gnt, 1);
    next_cyc();
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("rlock%0d_locked", k), locked, 1);
      chk($sformatf("rlock%0d_mem_write", k), mem_write, 1);
      next_cyc();
    end
    rst = 1'b1; ldr_addr = 8'h70; ldr_wdata = 8'hEE;
    @(negedge clk);
    chk("rlock5_mem_write", mem_write, 0);
    chk("rlock5_ldr_gnt", ldr_gnt, 0);
    next_cyc();
    rst = 1'b0; ldr_req = 1'b0; ldr_lock = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h70;
    @(negedge clk);
    chk("rlock6_locked", locked, 0);
    chk("rlock6_cpu_gnt", cpu_gnt, 1);
    chk("rlock6_rdata", cpu_rdata, 8'h00);
    chk("rlock6_conflict", conflict_cnt, 0);

    // Saturation of the contention counter
    ldr_req = 1'b1;
    repeat (65534) next_cyc();
    chk("sat_fffe", conflict_cnt, 16'hFFFE);
    next_cyc();
    chk("sat_ffff", conflict_cnt, 16'hFFFF);
    repeat (4465) next_cyc();
    chk("sat_hold", conflict_cnt, 16'hFFFF);
    chk("sat_d1_hold", d1_conflict_cnt, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single 256×8 memory port between two requesters:
- the CPU (controller/datapath pair);
- a program loader (boot/DMA engine that fills memory before and during execution).

It sits between both requesters and the memory unit, and multiplexes address, write data and write strobe. The CPU has priority, with a starvation guard so the loader always makes progress. A lock mode lets the loader own the port for a whole boot image. The block stalls the losing requester and keeps a saturating contention counter for debug.

## Interface
Parameters:
- AW, 8, address width
- DW, 8, data width
- STARVE_MAX, 4, consecutive denied loader cycles before the loader is forced a grant (≥1)

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk  in  1  system clock
  - rst  in  1  synchronous active-high reset
- CPU requester:
  - cpu_req  in  1  CPU memory access request
  - cpu_we  in  1  CPU write (1) / read (0)
  - cpu_addr  in  AW  CPU address
  - cpu_wdata  in  DW  CPU write data
  - cpu_rdata  out  DW  read data to CPU
  - cpu_gnt  out  1  CPU access performed this cycle
  - cpu_stall  out  1  cpu_req & ~cpu_gnt
- Loader requester:
  - ldr_req  in  1  loader request
  - ldr_we  in  1  loader write/read
  - ldr_addr  in  AW  loader address
  - ldr_wdata  in  DW  loader write data
  - ldr_lock  in  1  loader requests exclusive ownership
  - ldr_rdata  out  DW  read data to loader
  - ldr_gnt  out  1  loader access performed this cycle
- Memory side:
  - mem_addr  out  AW  memory address
  - mem_wdata  out  DW  memory write data
  - mem_write  out  1  memory write strobe
  - mem_rdata  in  DW  memory asynchronous read data
- Debug:
  - locked  out  1  FSM in LOCK
  - conflict_cnt  out  16  saturating count of cycles with cpu_req & ldr_req

## Operation
- FSM has two states: ARB and LOCK.
- Grants are combinational from registered state plus current requests. At most one grant per cycle.
- Grant rules in ARB, evaluated in order:
  1. ldr_req & (ldr_lock | ~cpu_req | starve_cnt == STARVE_MAX) → ldr_gnt.
  2. Else cpu_req → cpu_gnt.
  3. Else no grant.
- Grant rules in LOCK:
  - ldr_gnt = ldr_req; cpu_gnt = 0 unconditionally.
- ARB → LOCK when ldr_gnt & ldr_lock.
- LOCK → ARB on the first cycle with ldr_lock = 0. The grant in that cycle already follows LOCK rules; ARB rules apply from the next cycle.
- starve_cnt (width clog2(STARVE_MAX+1)):
  - increments, saturating at STARVE_MAX, when ldr_req & ~ldr_gnt;
  - clears when ldr_gnt or ~ldr_req.
- CPU starvation during loader activity is allowed only in LOCK. Outside LOCK the loader can win at most one consecutive cycle under contention, because starve_cnt clears on its grant.
- Memory mux:
  - the granted requester drives mem_addr/mem_wdata;
  - mem_write = granted requester's we;
  - with no grant, mem_addr = cpu_addr, mem_wdata = cpu_wdata, mem_write = 0.
- Read data: cpu_rdata = ldr_rdata = mem_rdata, broadcast. Valid only in the requester's grant cycle.
- conflict_cnt increments each cycle with cpu_req & ldr_req, regardless of state, and saturates at 0xFFFF.

## Timing
- Zero-latency grant:
  - a read's data is valid in the grant cycle;
  - a write commits at the clk edge ending the grant cycle.
- A request not granted must be held stable by its requester until granted. The arbiter does not latch requests.
- Reset values (rst high at clock edge): state ARB, starve_cnt 0, conflict_cnt 0, locked 0.
- While rst is high, all grants are 0, mem_write is 0 and cpu_stall = cpu_req.
- Reset mid-LOCK returns to ARB; any write pending in the reset cycle is suppressed.
- Simultaneous requests with starve_cnt < STARVE_MAX and ldr_lock = 0: CPU wins, loader stalls.
- STARVE_MAX = 1: under continuous contention, grants alternate CPU, LDR, CPU, LDR…
- ldr_lock asserted while the loader is denied has no effect until the loader is granted.

## Structure
- Shared package risc_spm_pkg holds:
  - AW/DW defaults;
  - arb_state_t enum {ARB, LOCK};
  - CNT_W = 16.
- The saturating counter is used twice (starve_cnt, conflict_cnt). It is the one natural sub-module: sat_counter, with parameter W and ports clr, inc, max, q.
- The FSM and the mux stay in mem_port_arbiter.

## Test plan
- Reset: assert rst with cpu_req = ldr_req = 1 and both we = 1 → all grants 0, mem_write 0, conflict_cnt stays 0.
- CPU alone: cpu_req = 1, cpu_we = 1, cpu_addr = 0x10, cpu_wdata = 0xA5 → cpu_gnt = 1 the same cycle, mem_write = 1, mem_addr = 0x10; a later read of 0x10 returns 0xA5.
- Contention, STARVE_MAX = 4, both requesting continuously:
  - grant pattern is CPU×4, LDR, CPU×4, LDR…;
  - cpu_stall is high only in the LDR cycles;
  - conflict_cnt = 10 after 10 cycles.
- Lock: loader granted with ldr_lock = 1 at cycle t:
  - locked = 1 from t+1;
  - cpu_gnt = 0 throughout even with cpu_req = 1 and ldr_req = 0;
  - drop ldr_lock at t+20 → CPU granted at t+21.
- Reset mid-lock: rst at t+5 of a lock → no write at t+5, ARB at t+6 and the CPU is granted.
- Saturation: preload or run 70000 contention cycles → conflict_cnt holds 0xFFFF.
